gat_bram_load_ctrl: RTL and testbench
=====================================

Name: gat_bram_load_ctrl

Overview:
- Parametrised, multi-channel host-to-core BRAM load controller between the AXI-BRAM block-design ports and gat_top.
- Converts byte addresses to word addresses and truncates 32-bit host data to each channel's core width.
- Counts accepted writes per channel against a programmed word count, and flags misaligned or out-of-range writes.
- Sequences load, start and run phases, and drives per-channel load-done signals and the gat_ready / debug status to the register bank.

Parameters:
- TOP_WIDTH, 32, host data width.
- NUM_CH, 4, number of load channels (0 = h_data, 1 = node_info, 2 = weight, 3 = subgraph).
- CH_DATA_W, 24, core-side data width (uniform; each channel consumes its low bits).
- CH_ADDR_W, 19, core-side word-address width (uniform, covers the largest depth).
- CNT_W, CH_ADDR_W+1, word-counter width.
- FEAT_ADDR_W, 16, new-feature word-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- host_din  in  NUM_CH*TOP_WIDTH  packed host write data, channel c at [c*TOP_WIDTH +: TOP_WIDTH]
- host_ena  in  NUM_CH  per-channel enable
- host_wea  in  NUM_CH  per-channel write enable
- host_addra  in  NUM_CH*(CH_ADDR_W+2)  packed byte addresses
- cfg_words  in  NUM_CH*CNT_W  expected word count per channel; sampled on leaving IDLE
- cfg_start  in  1  pulse: arm the load
- cfg_clear  in  1  synchronous soft clear back to IDLE
- core_din  out  NUM_CH*CH_DATA_W  registered data to the core BRAMs
- core_ena  out  NUM_CH  registered enable
- core_wea  out  NUM_CH  registered write enable
- core_addra  out  NUM_CH*CH_ADDR_W  registered word addresses
- core_load_done  out  NUM_CH  per-channel load done, level
- core_ready  in  1  gat_top completion, level
- feat_addrb_byte  in  FEAT_ADDR_W+2  host byte read address
- feat_addrb  out  FEAT_ADDR_W  combinational word address = feat_addrb_byte[FEAT_ADDR_W+1:2]
- gat_ready  out  1  run complete
- gat_debug_1  out  TOP_WIDTH  {state[2:0], err_flags[NUM_CH-1:0], done[NUM_CH-1:0]} zero-extended
- gat_debug_2  out  TOP_WIDTH  channel-0 word count, zero-extended
- gat_debug_3  out  TOP_WIDTH  cycle counter in RUN, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and counters are 0; state = IDLE.
- States: IDLE, LOAD, RUN, DONE.
- Write path, in any state:
  - core_* = previous-cycle host_* (one register stage).
  - core_addra = host_addra[CH_ADDR_W+1:2].
  - core_din = host_din[CH_DATA_W-1:0].
  - Writes pass through even in IDLE; they are counted only in LOAD.
- Accept condition, per channel: ena & wea & state == LOAD & !done[c].
  - An accepted write increments cnt[c].
  - done[c] sets when cnt[c]+1 == words[c], and also in the same cycle LOAD is entered if words[c] == 0.
  - Writes after done are still forwarded but not counted.
- Error flags: err[c] is sticky and set on any ena & wea write in LOAD where:
  - addr[1:0] != 0, or
  - word address >= words[c].
  - The offending write is still forwarded and still counted. Host reload is the recovery path.
- State transitions:
  - IDLE -> LOAD on cfg_start: words latched, cnt cleared, err cleared.
  - LOAD -> RUN when &done.
  - RUN -> DONE on core_ready.
  - DONE -> IDLE on cfg_start (re-arm, which also performs the IDLE->LOAD actions in the same cycle).
- core_load_done = done[c] registered, held through RUN and DONE; cleared on entry to LOAD.
- gat_ready = 1 only in DONE.
- RUN cycle counter: cleared on LOAD entry, increments each RUN cycle, saturates at all-ones.
- cfg_clear has priority over every transition: state -> IDLE, done/err/cnt cleared, output pipeline flushed next cycle.
- cfg_start outside IDLE/DONE is ignored.
- Simultaneous completion: a write completing the last channel moves the FSM to RUN the next cycle; core_load_done rises in that same cycle.

Decomposition:
- Package gat_load_pkg holds:
  - state enum,
  - channel index constants CH_HDATA/CH_NODE/CH_WGT/CH_SUBG,
  - function byte2word().
- Sub-module gat_load_ch_cnt: one per channel via generate. Holds counter, done and error logic for that channel. The top keeps the FSM and debug registers.

Test Plan:
- words = {4,2,3,1}; 10 aligned sequential writes on all channels -> done bits rise per channel; after the last write: RUN next cycle, core_load_done = 4'hF, gat_debug_1 done field = F.
- Ch0 write at byte addr 0x0000_0006 -> core_addra[0] = 1 one cycle later; err[0] = 1; debug_1 bit shows the error.
- Ch2 words = 3, write to byte addr 0xC (word 3) -> err[2] = 1 and cnt[2] increments.
- In RUN, hold core_ready low 50 cycles then high -> gat_debug_3 = 50; gat_ready = 1 the next cycle; cfg_start then returns to LOAD with cnt = 0 and err = 0.
- cfg_clear asserted mid-LOAD with done = 4'b0011 -> IDLE next cycle, done = 0, gat_ready = 0; a subsequent write in IDLE is forwarded but not counted.
- words[1] = 0 -> done[1] = 1 in the same cycle LOAD is entered; feat_addrb_byte = 0x0010 -> feat_addrb = 4; rst_n low asynchronously mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/gat_load_pkg.sv
// Shared types and helpers for the host-to-core BRAM load controller.
package gat_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3
    } gat_state_e;

    localparam int unsigned CH_HDATA = 0;
    localparam int unsigned CH_NODE  = 1;
    localparam int unsigned CH_WGT   = 2;
    localparam int unsigned CH_SUBG  = 3;

    // Byte address to 32-bit word address; callers truncate to their width.
    function automatic logic [31:0] byte2word(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/gat_load_ch_cnt.sv
// Per-channel word counter with completion and sticky address-error tracking.
module gat_load_ch_cnt
    import gat_load_pkg::*;
#(
    parameter int unsigned CH_ADDR_W = 19,
    parameter int unsigned CNT_W     = CH_ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load_entry,
    input  logic                 in_load,
    input  logic [CNT_W-1:0]     words_cfg,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [CH_ADDR_W+1:0] addr,
    output logic [CNT_W-1:0]     cnt,
    output logic                 done,
    output logic                 err,
    output logic                 done_nxt_c
);

    logic [CNT_W-1:0]     words_q;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CH_ADDR_W-1:0] waddr;
    logic                 wr_load;
    logic                 accept;
    logic                 bad_addr;

    assign waddr    = CH_ADDR_W'(byte2word(32'(addr)));
    assign wr_load  = ena & wea & in_load;
    assign accept   = wr_load & ~done;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign bad_addr = (addr[1:0] != 2'b00) || (CNT_W'(waddr) >= words_q);

    // Done rises on the accepted write that reaches the count, or at arm time for an empty load.
    always_comb begin
        done_nxt_c = done;
        if (clear) begin
            done_nxt_c = 1'b0;
        end else if (load_entry) begin
            done_nxt_c = (words_cfg == '0);
        end else if (accept && (cnt_inc == words_q)) begin
            done_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= done_nxt_c;
            if (clear) begin
                cnt <= '0;
                err <= 1'b0;
            end else if (load_entry) begin
                words_q <= words_cfg;
                cnt     <= '0;
                err     <= 1'b0;
            end else begin
                if (accept) begin
                    cnt <= cnt_inc;
                end
                if (wr_load && bad_addr) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gat_bram_load_ctrl.sv
// Host-to-core BRAM load controller: write forwarding, per-channel load tracking,
// load/run sequencing and status for the register bank.
module gat_bram_load_ctrl
    import gat_load_pkg::*;
#(
    parameter int unsigned TOP_WIDTH   = 32,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_DATA_W   = 24,
    parameter int unsigned CH_ADDR_W   = 19,
    parameter int unsigned CNT_W       = CH_ADDR_W + 1,
    parameter int unsigned FEAT_ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH*TOP_WIDTH-1:0]   host_din,
    input  logic [NUM_CH-1:0]             host_ena,
    input  logic [NUM_CH-1:0]             host_wea,
    input  logic [NUM_CH*(CH_ADDR_W+2)-1:0] host_addra,
    input  logic [NUM_CH*CNT_W-1:0]       cfg_words,
    input  logic                          cfg_start,
    input  logic                          cfg_clear,
    output logic [NUM_CH*CH_DATA_W-1:0]   core_din,
    output logic [NUM_CH-1:0]             core_ena,
    output logic [NUM_CH-1:0]             core_wea,
    output logic [NUM_CH*CH_ADDR_W-1:0]   core_addra,
    output logic [NUM_CH-1:0]             core_load_done,
    input  logic                          core_ready,
    input  logic [FEAT_ADDR_W+1:0]        feat_addrb_byte,
    output logic [FEAT_ADDR_W-1:0]        feat_addrb,
    output logic                          gat_ready,
    output logic [TOP_WIDTH-1:0]          gat_debug_1,
    output logic [TOP_WIDTH-1:0]          gat_debug_2,
    output logic [TOP_WIDTH-1:0]          gat_debug_3
);

    localparam int unsigned BA_W = CH_ADDR_W + 2;

    gat_state_e           state;
    gat_state_e           state_nxt;
    logic [NUM_CH-1:0]    done;
    logic [NUM_CH-1:0]    err;
    logic [NUM_CH-1:0]    done_nxt;
    logic [CNT_W-1:0]     cnt [NUM_CH];
    logic [TOP_WIDTH-1:0] run_cyc;
    logic                 load_entry;
    logic                 in_load;
    logic                 unused_host_din;

    // Host data above the core width is intentionally dropped.
    assign unused_host_din = ^host_din;

    assign in_load    = (state == ST_LOAD);
    assign load_entry = cfg_start && !cfg_clear && ((state == ST_IDLE) || (state == ST_DONE));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gat_load_ch_cnt #(
            .CH_ADDR_W (CH_ADDR_W),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (cfg_clear),
            .load_entry (load_entry),
            .in_load    (in_load),
            .words_cfg  (cfg_words[c*CNT_W +: CNT_W]),
            .ena        (host_ena[c]),
            .wea        (host_wea[c]),
            .addr       (host_addra[c*BA_W +: BA_W]),
            .cnt        (cnt[c]),
            .done       (done[c]),
            .err        (err[c]),
            .done_nxt_c (done_nxt[c])
        );
    end

    // Next-state: soft clear wins over every other transition.
    always_comb begin
        state_nxt = state;
        if (cfg_clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cfg_start)  state_nxt = ST_LOAD;
                ST_LOAD: if (&done_nxt)  state_nxt = ST_RUN;
                ST_RUN:  if (core_ready) state_nxt = ST_DONE;
                ST_DONE: if (cfg_start)  state_nxt = ST_LOAD;
                default:                 state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gat_ready <= 1'b0;
            run_cyc   <= '0;
        end else begin
            state     <= state_nxt;
            gat_ready <= (state_nxt == ST_DONE);
            if (load_entry) begin
                run_cyc <= '0;
            end else if ((state == ST_RUN) && (run_cyc != '1)) begin
                run_cyc <= run_cyc + TOP_WIDTH'(1);
            end
        end
    end

    // One-stage write forwarding to the core BRAMs, independent of load state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_din   <= '0;
            core_ena   <= '0;
            core_wea   <= '0;
            core_addra <= '0;
        end else if (cfg_clear) begin
            core_din   <= '0;
            core_ena   <= '0;
            core_wea   <= '0;
            core_addra <= '0;
        end else begin
            core_ena <= host_ena;
            core_wea <= host_wea;
            for (int c = 0; c < NUM_CH; c++) begin
                core_din[c*CH_DATA_W +: CH_DATA_W]   <= host_din[c*TOP_WIDTH +: CH_DATA_W];
                core_addra[c*CH_ADDR_W +: CH_ADDR_W] <=
                    CH_ADDR_W'(byte2word(32'(host_addra[c*BA_W +: BA_W])));
            end
        end
    end

    assign feat_addrb     = FEAT_ADDR_W'(byte2word(32'(feat_addrb_byte)));
    assign core_load_done = done;
    assign gat_debug_1    = TOP_WIDTH'({state, err, done});
    assign gat_debug_2    = TOP_WIDTH'(cnt[CH_HDATA]);
    assign gat_debug_3    = run_cyc;

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Directed bench for gat_bram_load_ctrl with hand-computed expectations.
module tb_gat_bram_load_ctrl;

    localparam int unsigned TOP_WIDTH   = 32;
    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned CH_DATA_W   = 24;
    localparam int unsigned CH_ADDR_W   = 19;
    localparam int unsigned CNT_W       = 20;
    localparam int unsigned FEAT_ADDR_W = 16;
    localparam int unsigned BA_W        = CH_ADDR_W + 2;

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b1;
    logic [NUM_CH*TOP_WIDTH-1:0]     host_din = '0;
    logic [NUM_CH-1:0]               host_ena = '0;
    logic [NUM_CH-1:0]               host_wea = '0;
    logic [NUM_CH*BA_W-1:0]          host_addra = '0;
    logic [NUM_CH*CNT_W-1:0]         cfg_words = '0;
    logic                            cfg_start = 1'b0;
    logic                            cfg_clear = 1'b0;
    logic [NUM_CH*CH_DATA_W-1:0]     core_din;
    logic [NUM_CH-1:0]               core_ena;
    logic [NUM_CH-1:0]               core_wea;
    logic [NUM_CH*CH_ADDR_W-1:0]     core_addra;
    logic [NUM_CH-1:0]               core_load_done;
    logic                            core_ready = 1'b0;
    logic [FEAT_ADDR_W+1:0]          feat_addrb_byte = '0;
    logic [FEAT_ADDR_W-1:0]          feat_addrb;
    logic                            gat_ready;
    logic [TOP_WIDTH-1:0]            gat_debug_1;
    logic [TOP_WIDTH-1:0]            gat_debug_2;
    logic [TOP_WIDTH-1:0]            gat_debug_3;

    int n_cmp  = 0;
    int n_fail = 0;

    gat_bram_load_ctrl #(
        .TOP_WIDTH   (TOP_WIDTH),
        .NUM_CH      (NUM_CH),
        .CH_DATA_W   (CH_DATA_W),
        .CH_ADDR_W   (CH_ADDR_W),
        .CNT_W       (CNT_W),
        .FEAT_ADDR_W (FEAT_ADDR_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_din        (host_din),
        .host_ena        (host_ena),
        .host_wea        (host_wea),
        .host_addra      (host_addra),
        .cfg_words       (cfg_words),
        .cfg_start       (cfg_start),
        .cfg_clear       (cfg_clear),
        .core_din        (core_din),
        .core_ena        (core_ena),
        .core_wea        (core_wea),
        .core_addra      (core_addra),
        .core_load_done  (core_load_done),
        .core_ready      (core_ready),
        .feat_addrb_byte (feat_addrb_byte),
        .feat_addrb      (feat_addrb),
        .gat_ready       (gat_ready),
        .gat_debug_1     (gat_debug_1),
        .gat_debug_2     (gat_debug_2),
        .gat_debug_3     (gat_debug_3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input logic [BA_W-1:0] baddr, input logic [31:0] data);
        host_ena[ch]               = 1'b1;
        host_wea[ch]               = 1'b1;
        host_addra[ch*BA_W +: BA_W] = baddr;
        host_din[ch*TOP_WIDTH +: TOP_WIDTH] = data;
    endtask

    task automatic no_wr();
        host_ena = '0;
        host_wea = '0;
    endtask

    function automatic logic [CH_ADDR_W-1:0] addr_of(input int ch);
        return core_addra[ch*CH_ADDR_W +: CH_ADDR_W];
    endfunction

    function automatic logic [CH_DATA_W-1:0] din_of(input int ch);
        return core_din[ch*CH_DATA_W +: CH_DATA_W];
    endfunction

    initial begin
        logic [31:0] dbg1_tab [4];
        logic [3:0]  ena_tab  [4];
        logic [3:0]  w_clean  [4];
        dbg1_tab = '{32'h108, 32'h10A, 32'h10E, 32'h20F};
        ena_tab  = '{4'hF, 4'h7, 4'h5, 4'h1};
        w_clean  = '{4'd4, 4'd2, 4'd3, 4'd1};

        // Reset
        #2 rst_n = 1'b0;
        step();
        chk("rst_core_ena", 64'(core_ena), 64'h0);
        chk("rst_load_done", 64'(core_load_done), 64'h0);
        chk("rst_gat_ready", 64'(gat_ready), 64'h0);
        chk("rst_debug_1", 64'(gat_debug_1), 64'h0);
        rst_n = 1'b1;
        step();

        // Feature read address
        feat_addrb_byte = 18'h00010;
        #1 chk("feat_addr_0x10", 64'(feat_addrb), 64'h4);
        feat_addrb_byte = 18'h3FFFF;
        #1 chk("feat_addr_max", 64'(feat_addrb), 64'hFFFF);
        feat_addrb_byte = '0;

        // Load 1: words ch0=4 ch1=0 ch2=3 ch3=1, with misaligned / out-of-range writes
        cfg_words = {20'd1, 20'd3, 20'd0, 20'd4};
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("l1_enter_dbg1", 64'(gat_debug_1), 64'h102);
        chk("l1_enter_done", 64'(core_load_done), 64'h2);
        wr(0, 21'h6, 32'hDEAD_BEEF);
        step();
        chk("l1_misalign_addr", 64'(addr_of(0)), 64'h1);
        chk("l1_misalign_din", 64'(din_of(0)), 64'hAD_BEEF);
        chk("l1_misalign_ena", 64'(core_ena), 64'h1);
        chk("l1_misalign_dbg1", 64'(gat_debug_1), 64'h112);
        chk("l1_misalign_cnt0", 64'(gat_debug_2), 64'h1);
        no_wr(); wr(2, 21'h0, 32'h1);
        step();
        no_wr(); wr(2, 21'h4, 32'h2);
        step();
        chk("l1_ch2_two_dbg1", 64'(gat_debug_1), 64'h112);
        no_wr(); wr(2, 21'hC, 32'h3);
        step();
        chk("l1_ch2_oor_addr", 64'(addr_of(2)), 64'h3);
        chk("l1_ch2_oor_dbg1", 64'(gat_debug_1), 64'h156);
        no_wr(); wr(0, 21'h4, 32'h4); wr(3, 21'h0, 32'h5);
        step();
        chk("l1_w5_dbg1", 64'(gat_debug_1), 64'h15E);
        chk("l1_w5_cnt0", 64'(gat_debug_2), 64'h2);
        no_wr(); wr(0, 21'h8, 32'h6);
        step();
        chk("l1_w6_cnt0", 64'(gat_debug_2), 64'h3);
        no_wr(); wr(0, 21'hC, 32'h7);
        step();
        no_wr();
        chk("l1_run_dbg1", 64'(gat_debug_1), 64'h25F);
        chk("l1_run_done", 64'(core_load_done), 64'hF);
        chk("l1_run_cnt0", 64'(gat_debug_2), 64'h4);
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        chk("l1_done_dbg1", 64'(gat_debug_1), 64'h35F);
        chk("l1_done_ready", 64'(gat_ready), 64'h1);
        chk("l1_done_cyc", 64'(gat_debug_3), 64'h1);

        // Load 2: re-arm from DONE, words ch0=4 ch1=2 ch2=3 ch3=1, clean sequential writes
        cfg_words = {20'd1, 20'd3, 20'd2, 20'd4};
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("l2_rearm_dbg1", 64'(gat_debug_1), 64'h100);
        chk("l2_rearm_cnt0", 64'(gat_debug_2), 64'h0);
        chk("l2_rearm_cyc", 64'(gat_debug_3), 64'h0);
        chk("l2_rearm_ready", 64'(gat_ready), 64'h0);
        chk("l2_rearm_done", 64'(core_load_done), 64'h0);
        for (int k = 0; k < 4; k++) begin
            no_wr();
            for (int ch = 0; ch < 4; ch++) begin
                if (k < int'(w_clean[ch])) wr(ch, BA_W'(4*k), 32'hA5C0_0000 + 32'(ch*32'h1000) + 32'(k));
            end
            step();
            chk($sformatf("l2_k%0d_dbg1", k), 64'(gat_debug_1), 64'(dbg1_tab[k]));
            chk($sformatf("l2_k%0d_ena", k), 64'(core_ena), 64'(ena_tab[k]));
            chk($sformatf("l2_k%0d_cnt0", k), 64'(gat_debug_2), 64'(k + 1));
            chk($sformatf("l2_k%0d_addr0", k), 64'(addr_of(0)), 64'(k));
            if (k == 1) chk("l2_k1_din1", 64'(din_of(1)), 64'hC0_1001);
        end
        no_wr();
        chk("l2_run_done", 64'(core_load_done), 64'hF);
        for (int i = 0; i < 49; i++) step();
        chk("l2_run49_cyc", 64'(gat_debug_3), 64'd49);
        chk("l2_run49_ready", 64'(gat_ready), 64'h0);
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        chk("l2_done_cyc", 64'(gat_debug_3), 64'd50);
        chk("l2_done_ready", 64'(gat_ready), 64'h1);
        chk("l2_done_dbg1", 64'(gat_debug_1), 64'h30F);
        step();
        chk("l2_hold_cyc", 64'(gat_debug_3), 64'd50);
        chk("l2_hold_done", 64'(core_load_done), 64'hF);

        // Load 3: soft clear mid-load, then an uncounted IDLE write
        cfg_words = {20'd2, 20'd2, 20'd1, 20'd1};
        cfg_start = 1'b1;
        step();
        chk("l3_enter_dbg1", 64'(gat_debug_1), 64'h100);
        wr(0, 21'h0, 32'h11); wr(1, 21'h0, 32'h22);
        step();
        cfg_start = 1'b0;
        chk("l3_start_ignored_dbg1", 64'(gat_debug_1), 64'h103);
        no_wr(); wr(2, 21'h0, 32'h33);
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        chk("l3_clear_dbg1", 64'(gat_debug_1), 64'h0);
        chk("l3_clear_ena", 64'(core_ena), 64'h0);
        chk("l3_clear_ready", 64'(gat_ready), 64'h0);
        chk("l3_clear_done", 64'(core_load_done), 64'h0);
        no_wr(); wr(2, 21'h4, 32'h1234_5678);
        step();
        no_wr();
        chk("l3_idle_ena", 64'(core_ena), 64'h4);
        chk("l3_idle_addr2", 64'(addr_of(2)), 64'h1);
        chk("l3_idle_din2", 64'(din_of(2)), 64'h34_5678);
        chk("l3_idle_dbg1", 64'(gat_debug_1), 64'h0);

        // Load 4: empty load goes straight through, then async reset mid-RUN
        cfg_words = '0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("l4_enter_dbg1", 64'(gat_debug_1), 64'h10F);
        step();
        chk("l4_run_dbg1", 64'(gat_debug_1), 64'h20F);
        wr(1, 21'h8, 32'h99);
        step();
        step();
        chk("l4_run_cyc", 64'(gat_debug_3), 64'h2);
        chk("l4_run_ena", 64'(core_ena), 64'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ena", 64'(core_ena), 64'h0);
        chk("arst_addra", 64'(core_addra), 64'h0);
        chk("arst_din", 64'(core_din), 64'h0);
        chk("arst_done", 64'(core_load_done), 64'h0);
        chk("arst_dbg1", 64'(gat_debug_1), 64'h0);
        chk("arst_dbg3", 64'(gat_debug_3), 64'h0);
        chk("arst_ready", 64'(gat_ready), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
